mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: multi-cycle data-memory access with stall handshake.
// Optional byte (lb/sb) support enabled by defining MEM_STAGE_BYTE_ACCESS_EN.
module mem_stage #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned MEM_WORDS   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_MEM,
   input  logic        mem_write_MEM,
   input  logic        mem_byte_MEM,
   input  logic [31:0] ALU_out_MEM,
   input  logic [31:0] write_data_MEM,
   output logic [31:0] read_data_MEM,
   output logic        stall_MEM,
   output logic        misaligned_MEM
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = 4;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   mem_q [MEM_WORDS] = '{default: '0};

   logic          byte_c, req_c, commit_c, we_c;
   logic [AW-1:0] idx_c;
   logic [4:0]    lane_sel_c;
   logic [7:0]    lane_c;
   logic [31:0]   word_c, wword_c, lval_c;
   logic          unused_c;

`ifdef MEM_STAGE_BYTE_ACCESS_EN
   assign byte_c = mem_byte_MEM;
`else
   logic unused_byte_c;
   assign byte_c        = 1'b0;
   assign unused_byte_c = mem_byte_MEM;
`endif

   // Upper address bits are ignored so accesses wrap around the array.
   assign unused_c   = &{1'b0, ALU_out_MEM[31:AW+2]};
   assign idx_c      = ALU_out_MEM[AW+1:2];
   assign lane_sel_c = {ALU_out_MEM[1:0], 3'b000};
   assign word_c     = mem_q[idx_c];
   assign lane_c     = word_c[lane_sel_c +: 8];
   assign lval_c     = byte_c ? {{24{lane_c[7]}}, lane_c} : word_c;

   always_comb begin
      wword_c = word_c;
      if (byte_c) wword_c[lane_sel_c +: 8] = write_data_MEM[7:0];
      else        wword_c = write_data_MEM;
   end

   assign misaligned_MEM = (mem_read_MEM | mem_write_MEM) & ~byte_c & (ALU_out_MEM[1:0] != 2'b00);
   assign req_c          = (mem_read_MEM | mem_write_MEM) & ~misaligned_MEM;
   assign stall_MEM      = ~rst & (((state_q == IDLE) & req_c) | (state_q == ACCESS));

   // Next-state, wait counter and load-data capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      commit_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_c) begin
               state_d = ACCESS;
               cnt_d   = CW'(MEM_LATENCY - 1);
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               commit_c = 1'b1;
               state_d  = DONE;
               if (mem_read_MEM && !mem_write_MEM) rdata_d = lval_c;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory is never reset; a commit edge seen under reset is discarded.
   assign we_c = commit_c & mem_write_MEM & ~rst;

   always_ff @(posedge clk) begin
      if (we_c) mem_q[idx_c] <= wword_c;
   end

   assign read_data_MEM = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default parameters).
// Byte-access checks follow MEM_STAGE_BYTE_ACCESS_EN when defined.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_MEM, mem_write_MEM, mem_byte_MEM;
   logic [31:0] ALU_out_MEM, write_data_MEM;
   logic [31:0] read_data_MEM;
   logic        stall_MEM, misaligned_MEM;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage dut (
      .clk            (clk),
      .rst            (rst),
      .mem_read_MEM   (mem_read_MEM),
      .mem_write_MEM  (mem_write_MEM),
      .mem_byte_MEM   (mem_byte_MEM),
      .ALU_out_MEM    (ALU_out_MEM),
      .write_data_MEM (write_data_MEM),
      .read_data_MEM  (read_data_MEM),
      .stall_MEM      (stall_MEM),
      .misaligned_MEM (misaligned_MEM)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic rd, input logic wr, input logic byt,
                        input logic [31:0] a, input logic [31:0] d);
      mem_read_MEM   = rd;
      mem_write_MEM  = wr;
      mem_byte_MEM   = byt;
      ALU_out_MEM    = a;
      write_data_MEM = d;
   endtask

   // Drives a request now, counts stalled negedges, returns in DONE with inputs held.
   task automatic access(input logic rd, input logic wr, input logic byt,
                         input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic [31:0] rdat);
      logic done;
      done   = 1'b0;
      stalls = 0;
      drive(rd, wr, byt, a, d);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (stall_MEM) stalls++;
         else begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL timeout addr=%h: stall stuck high", a);
      end
      rdat = read_data_MEM;
   endtask

   task automatic go_idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (stall_MEM !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_MEM); end
      n_cmp++; if (read_data_MEM !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", read_data_MEM); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_mem();
      int s; logic [31:0] r;
      access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, s, r);
      n_cmp++; if (s !== 3) begin n_err++; $display("FAIL zero_stalls got=%0d exp=3", s); end
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL zero_rdata got=%h exp=0", r); end
      go_idle();
   endtask

   task automatic test_store_load();
      int s; logic [31:0] r;
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, s, r);
      n_cmp++; if (s !== 3) begin n_err++; $display("FAIL sw_stalls got=%0d exp=3", s); end
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL sw_rdata_hold got=%h exp=0", r); end
      go_idle();
      access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, s, r);
      n_cmp++; if (s !== 3) begin n_err++; $display("FAIL lw_stalls got=%0d exp=3", s); end
      n_cmp++; if (r !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata got=%h exp=deadbeef", r); end
      go_idle();
      n_cmp++; if (read_data_MEM !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata_held got=%h exp=deadbeef", read_data_MEM); end
   endtask

   task automatic test_misaligned();
      int s; logic [31:0] r;
      drive(1'b1, 1'b0, 1'b0, 32'h13, 32'h0);
      #1;
      n_cmp++; if (misaligned_MEM !== 1'b1) begin n_err++; $display("FAIL mis_rd_flag got=%b exp=1", misaligned_MEM); end
      repeat (3) @(negedge clk);
      n_cmp++; if (stall_MEM !== 1'b0) begin n_err++; $display("FAIL mis_rd_stall got=%b exp=0", stall_MEM); end
      n_cmp++; if (read_data_MEM !== 32'hDEADBEEF) begin n_err++; $display("FAIL mis_rd_rdata got=%h exp=deadbeef", read_data_MEM); end
      drive(1'b0, 1'b1, 1'b0, 32'h22, 32'h55555555);
      repeat (3) @(negedge clk);
      n_cmp++; if (misaligned_MEM !== 1'b1 || stall_MEM !== 1'b0) begin n_err++; $display("FAIL mis_wr got=%b/%b exp=1/0", misaligned_MEM, stall_MEM); end
      drive(1'b0, 1'b0, 1'b0, 32'h13, 32'h0);
      #1;
      n_cmp++; if (misaligned_MEM !== 1'b0) begin n_err++; $display("FAIL mis_norq got=%b exp=0", misaligned_MEM); end
      @(posedge clk); #1;
      access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, s, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL mis_nowrite got=%h exp=0", r); end
      go_idle();
   endtask

   task automatic test_wrap();
      int s; logic [31:0] r;
      access(1'b0, 1'b1, 1'b0, 32'h110, 32'hCAFEF00D, s, r);
      go_idle();
      access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, s, r);
      n_cmp++; if (r !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap got=%h exp=cafef00d", r); end
      go_idle();
   endtask

   task automatic test_both();
      int s; logic [31:0] r;
      access(1'b1, 1'b1, 1'b0, 32'h30, 32'h11112222, s, r);
      n_cmp++; if (r !== 32'hCAFEF00D) begin n_err++; $display("FAIL both_hold got=%h exp=cafef00d", r); end
      go_idle();
      access(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, s, r);
      n_cmp++; if (r !== 32'h11112222) begin n_err++; $display("FAIL both_store got=%h exp=11112222", r); end
      go_idle();
   endtask

   task automatic test_back_to_back();
      int s; logic [31:0] r;
      access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0BADF00D, s, r);
      n_cmp++; if (r !== 32'h11112222) begin n_err++; $display("FAIL b2b_hold got=%h exp=11112222", r); end
      access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, s, r);
      n_cmp++; if (s !== 3) begin n_err++; $display("FAIL b2b_stalls got=%0d exp=3", s); end
      n_cmp++; if (r !== 32'h0BADF00D) begin n_err++; $display("FAIL b2b_rdata got=%h exp=0badf00d", r); end
      go_idle();
      repeat (3) begin
         @(negedge clk);
         n_cmp++; if (stall_MEM !== 1'b0) begin n_err++; $display("FAIL idle_stall got=%b exp=0", stall_MEM); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_access();
      int s; logic [31:0] r;
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (stall_MEM !== 1'b0) begin n_err++; $display("FAIL rst_acc_stall got=%b exp=0", stall_MEM); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (read_data_MEM !== 32'h0) begin n_err++; $display("FAIL rst_acc_rdata got=%h exp=0", read_data_MEM); end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (stall_MEM !== 1'b0) begin n_err++; $display("FAIL rst_acc_idle got=%b exp=0", stall_MEM); end
      @(posedge clk); #1;
      access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, s, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL rst_acc_nowrite got=%h exp=0", r); end
      access(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, s, r);
      n_cmp++; if (r !== 32'h11112222) begin n_err++; $display("FAIL rst_keeps_mem got=%h exp=11112222", r); end
      go_idle();
   endtask

   task automatic test_byte();
      int s; logic [31:0] r;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, s, r);
      go_idle();
      access(1'b0, 1'b1, 1'b1, 32'h11, 32'hAAAAAA80, s, r);
      n_cmp++; if (s !== 3) begin n_err++; $display("FAIL sb_stalls got=%0d exp=3", s); end
      go_idle();
      access(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, s, r);
      n_cmp++; if (r !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_11 got=%h exp=ffffff80", r); end
      go_idle();
      access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, s, r);
      n_cmp++; if (r !== 32'hDEAD80EF) begin n_err++; $display("FAIL sb_word got=%h exp=dead80ef", r); end
      go_idle();
      access(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, s, r);
      n_cmp++; if (r !== 32'hFFFFFFAD) begin n_err++; $display("FAIL lb_12 got=%h exp=ffffffad", r); end
      go_idle();
      access(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, s, r);
      n_cmp++; if (r !== 32'hFFFFFFDE) begin n_err++; $display("FAIL lb_13 got=%h exp=ffffffde", r); end
      go_idle();
`else
      drive(1'b1, 1'b0, 1'b1, 32'h11, 32'h0);
      @(negedge clk);
      n_cmp++; if (misaligned_MEM !== 1'b1 || stall_MEM !== 1'b0) begin n_err++; $display("FAIL nobyte_mis got=%b/%b exp=1/0", misaligned_MEM, stall_MEM); end
      go_idle();
      access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, s, r);
      n_cmp++; if (r !== 32'hCAFEF00D) begin n_err++; $display("FAIL nobyte_lw got=%h exp=cafef00d", r); end
      go_idle();
      access(1'b0, 1'b1, 1'b1, 32'h10, 32'h00000099, s, r);
      go_idle();
      access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, s, r);
      n_cmp++; if (r !== 32'h00000099) begin n_err++; $display("FAIL nobyte_sw got=%h exp=00000099", r); end
      go_idle();
`endif
   endtask

   initial begin
      test_reset();
      test_zero_mem();
      test_store_load();
      test_misaligned();
      test_wrap();
      test_both();
      test_back_to_back();
      test_reset_access();
      test_byte();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
